// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin pick function for arb_rr4_lock
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_t;

  // Returns {found, idx}: first requester at or after ptr (mod NUM_REQ) not masked by excl_mask.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr,
                                            input logic [NUM_REQ-1:0] excl_mask);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + ID_W'(i);
      if (!found && req[cand] && !excl_mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/decoder2_4.sv
// rtl/decoder2_4.sv - 2-to-4 one-hot decoder with enable
module decoder2_4 (
  input  logic [1:0] in,
  input  logic       ena,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (ena) out[in] = 1'b1;
  end

endmodule

// File: rtl/arb_rr4_lock.sv
// rtl/arb_rr4_lock.sv - 4-way round-robin arbiter with grant lock
// Optional hold timeout with preemption enabled by ARB_TIMEOUT_EN.
module arb_rr4_lock
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               preempt
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            vld_q, vld_d;
  logic            pre_q, pre_d;
  logic [ID_W:0]   pick_all;

  assign pick_all = rr_pick(req, ptr_q, '0);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic [ID_W:0]    pick_excl;

  assign pick_excl = rr_pick(req, ptr_q, NUM_REQ'(1) << id_q);
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD > CNT_W);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    vld_d   = vld_q;
    pre_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_all[ID_W]) begin
          state_d = S_GRANT;
          id_d    = pick_all[ID_W-1:0];
          vld_d   = 1'b1;
          ptr_d   = pick_all[ID_W-1:0] + 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[id_q]) begin
          // Owner released: hand over directly, no idle bubble.
          if (pick_all[ID_W]) begin
            id_d   = pick_all[ID_W-1:0];
            ptr_d  = pick_all[ID_W-1:0] + 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_d = '0;
`endif
          end else begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          // Saturated counter keeps preemption armed until a competitor shows up.
          if (hold_q >= HOLD_LAST && pick_excl[ID_W]) begin
            id_d   = pick_excl[ID_W-1:0];
            ptr_d  = pick_excl[ID_W-1:0] + 1'b1;
            hold_d = '0;
            pre_d  = 1'b1;
          end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      pre_q   <= pre_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt_id  = id_q;
  assign gnt_vld = vld_q;
  assign preempt = pre_q;

  decoder2_4 u_gnt_dec (
    .in  (id_q),
    .ena (vld_q),
    .out (gnt)
  );

endmodule
